// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI mode 3 byte master.
//   - spi_state_e : transaction FSM encoding
//   - SPI_BITS    : bits per transaction
//   - SCLK_IDLE / SS_IDLE : mode 3 idle levels of the bus pins
//   - cnt_width() : counter width for a modulus (at least 1 bit)
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int unsigned SPI_BITS  = 8;
    localparam logic        SCLK_IDLE = 1'b1;
    localparam logic        SS_IDLE   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOW,
        ST_HIGH,
        ST_HOLD,
        ST_GAP
    } spi_state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// -----------------------------------------------------------------------------
// spi_clk_div
// SCLK half-period counter. Counts 0..CLK_DIV-1 and raises `tick` on the
// last count; the count wraps to 0 on tick, so every FSM state change (which
// only happens on tick) restarts the half period from 0.
//   sysClk   : system clock
//   usrReset : synchronous active-high reset
//   clear    : hold the count at 0 (used while the FSM is idle)
//   tick     : high during the last cycle of a half period
// -----------------------------------------------------------------------------
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 8
) (
    input  logic sysClk,
    input  logic usrReset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned          CNT_W    = cnt_width(CLK_DIV);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    assign tick = (r_cnt == CNT_LAST);

    always_ff @(posedge sysClk) begin
        if (usrReset || clear || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_byte.sv
// -----------------------------------------------------------------------------
// spi_master_byte
// SPI mode 3 (CPOL=1, CPHA=1) master moving one byte per transaction,
// MSB first. A byte is accepted on txValid && txReady; SS, SCLK and MOSI are
// driven from registers, MISO is resynchronised and shifted into the same
// register that shifts the transmit byte out.
//   sysClk   in   system clock
//   usrReset in   synchronous active-high reset (abandons any transfer)
//   txValid  in   byte on `tx` is offered
//   txReady  out  idle, a byte is accepted this cycle
//   tx       in   byte to transmit, captured on accept
//   rxValid  out  one-cycle pulse, `rx` holds a new byte
//   rx       out  last received byte
//   SCLK     out  SPI clock, idles high
//   MOSI     out  master out, changes on SCLK falling edges, idles high
//   MISO     in   slave out, asynchronous, sampled on SCLK rising edges
//   SS       out  slave select, active low
// Parameter CLK_DIV: SCLK half period in sysClk cycles (4 or more).
// -----------------------------------------------------------------------------
module spi_master_byte
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 8
) (
    input  logic                sysClk,
    input  logic                usrReset,
    input  logic                txValid,
    output logic                txReady,
    input  logic [SPI_BITS-1:0] tx,
    output logic                rxValid,
    output logic [SPI_BITS-1:0] rx,
    output logic                SCLK,
    output logic                MOSI,
    input  logic                MISO,
    output logic                SS
);

    localparam int unsigned      BIT_W    = cnt_width(SPI_BITS);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SPI_BITS - 1);

    spi_state_e          r_state;
    spi_state_e          w_next;

    logic                w_tick;
    logic                w_div_clear;
    logic                w_accept;
    logic                w_fall;
    logic                w_rise;
    logic                w_end;

    logic [SPI_BITS-1:0] r_shift;
    logic [SPI_BITS-1:0] r_rx;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic                r_bit_done;
    logic                r_sclk;
    logic                r_ss;
    logic                r_mosi;
    logic                r_rxv;
    logic                r_miso_meta;
    logic                r_miso_sync;

    // The divider only needs holding while idle: all other state changes
    // happen on tick, which already wraps the count.
    assign w_div_clear = (r_state == ST_IDLE);

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .sysClk   (sysClk),
        .usrReset (usrReset),
        .clear    (w_div_clear),
        .tick     (w_tick)
    );

    // MISO is asynchronous to sysClk.
    always_ff @(posedge sysClk) begin
        if (usrReset) begin
            r_miso_meta <= 1'b0;
            r_miso_sync <= 1'b0;
        end else begin
            r_miso_meta <= MISO;
            r_miso_sync <= r_miso_meta;
        end
    end

    always_ff @(posedge sysClk) begin
        if (usrReset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The eighth rising edge enters HOLD directly, so HOLD doubles as the
    // last SCLK-high half period; this keeps SS low for exactly 17 half
    // periods and the byte period at 18*CLK_DIV+1.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_fall   = 1'b0;
        w_rise   = 1'b0;
        w_end    = 1'b0;
        txReady  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                txReady = 1'b1;
                if (txValid) begin
                    w_accept = 1'b1;
                    w_next   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (w_tick) begin
                    w_fall = 1'b1;
                    w_next = ST_LOW;
                end
            end
            ST_LOW: begin
                if (w_tick) begin
                    w_rise = 1'b1;
                    w_next = r_bit_done ? ST_HOLD : ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (w_tick) begin
                    w_fall = 1'b1;
                    w_next = ST_LOW;
                end
            end
            ST_HOLD: begin
                if (w_tick) begin
                    w_end  = 1'b1;
                    w_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_tick) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Bus pins, shift register and bit counter. The bit counter counts
    // falling edges; the done flag marks that the last bit is on the wire.
    always_ff @(posedge sysClk) begin
        if (usrReset) begin
            r_sclk     <= SCLK_IDLE;
            r_ss       <= SS_IDLE;
            r_mosi     <= 1'b1;
            r_rxv      <= 1'b0;
            r_rx       <= '0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_bit_done <= 1'b0;
        end else begin
            r_rxv <= w_end;
            if (w_accept) begin
                r_shift    <= tx;
                r_ss       <= ~SS_IDLE;
                r_bit_cnt  <= '0;
                r_bit_done <= 1'b0;
            end
            if (w_fall) begin
                r_sclk    <= ~SCLK_IDLE;
                r_mosi    <= r_shift[SPI_BITS-1];
                r_bit_cnt <= r_bit_cnt + 1'b1;
                if (r_bit_cnt == BIT_LAST) begin
                    r_bit_done <= 1'b1;
                end
            end
            if (w_rise) begin
                r_sclk  <= SCLK_IDLE;
                r_shift <= {r_shift[SPI_BITS-2:0], r_miso_sync};
            end
            if (w_end) begin
                r_ss   <= SS_IDLE;
                r_mosi <= 1'b1;
                r_rx   <= r_shift;
            end
        end
    end

    assign SCLK    = r_sclk;
    assign SS      = r_ss;
    assign MOSI    = r_mosi;
    assign rxValid = r_rxv;
    assign rx      = r_rx;

endmodule

// File: tb/tb_spi_master_byte.sv
module tb_spi_master_byte;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       usrReset;
    logic       txValid;
    logic [7:0] tx;
    logic       sel;          // 0: CLK_DIV=8 instance, 1: CLK_DIV=4 instance
    logic       txValid8, txValid4;
    logic       ready8, rxv8, sclk8, mosi8, ss8;
    logic       ready4, rxv4, sclk4, mosi4, ss4;
    logic [7:0] rx8, rx4;
    logic       w_miso;

    logic       m_ready, m_rxv, m_sclk, m_mosi, m_ss;
    logic [7:0] m_rx;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    // slave model state
    int         miso_mode = 0;  // 0: slave model, 1: constant 0, 2: constant 1
    logic       echo_en = 1'b0;
    logic [7:0] s_ret = 8'h00;
    logic [7:0] s_tx = 8'h00;
    logic [7:0] s_rx = 8'h00;
    logic [7:0] s_echo = 8'h00;
    logic [2:0] s_bit = 3'd7;
    logic       s_miso = 1'b1;

    assign txValid8 = txValid & ~sel;
    assign txValid4 = txValid & sel;
    assign w_miso   = (miso_mode == 0) ? s_miso : (miso_mode == 2);

    assign m_ready = sel ? ready4 : ready8;
    assign m_rxv   = sel ? rxv4   : rxv8;
    assign m_sclk  = sel ? sclk4  : sclk8;
    assign m_mosi  = sel ? mosi4  : mosi8;
    assign m_ss    = sel ? ss4    : ss8;
    assign m_rx    = sel ? rx4    : rx8;

    spi_master_byte #(.CLK_DIV(8)) u_dut8 (
        .sysClk(clk), .usrReset(usrReset), .txValid(txValid8), .txReady(ready8),
        .tx(tx), .rxValid(rxv8), .rx(rx8), .SCLK(sclk8), .MOSI(mosi8),
        .MISO(w_miso), .SS(ss8)
    );

    spi_master_byte #(.CLK_DIV(4)) u_dut4 (
        .sysClk(clk), .usrReset(usrReset), .txValid(txValid4), .txReady(ready4),
        .tx(tx), .rxValid(rxv4), .rx(rx4), .SCLK(sclk4), .MOSI(mosi4),
        .MISO(w_miso), .SS(ss4)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Mode 3 slave: drives MISO on SCLK falls, samples MOSI on SCLK rises.
    always @(negedge m_ss or negedge m_sclk) begin
        if (m_sclk) begin
            s_tx  = echo_en ? s_echo : s_ret;
            s_bit = 3'd7;
        end else if (!m_ss) begin
            s_miso = s_tx[s_bit];
            s_bit  = s_bit - 3'd1;
        end
    end

    always @(posedge m_sclk or posedge m_ss) begin
        if (m_ss) s_echo = s_rx;
        else      s_rx   = {s_rx[6:0], m_mosi};
    end

    // Event recorder, sampled on the falling sysClk edge.
    int         fall_q[$], rise_q[$], ssfall_q[$], ssrise_q[$];
    int         rdyfall_q[$], rdyrise_q[$], rxv_cyc_q[$];
    logic       mosi_rise_q[$];
    logic [7:0] rxv_dat_q[$];
    int         overlap_cnt = 0;
    logic       p_sclk = 1'b1, p_ss = 1'b1, p_rdy = 1'b1;

    always @(negedge clk) begin
        if (m_rxv) begin
            rxv_cyc_q.push_back(cyc);
            rxv_dat_q.push_back(m_rx);
        end
        if (m_rxv && m_ready) overlap_cnt = overlap_cnt + 1;
        if (p_sclk && !m_sclk) fall_q.push_back(cyc);
        if (!p_sclk && m_sclk) begin
            rise_q.push_back(cyc);
            mosi_rise_q.push_back(m_mosi);
        end
        if (p_ss && !m_ss) ssfall_q.push_back(cyc);
        if (!p_ss && m_ss) ssrise_q.push_back(cyc);
        if (p_rdy && !m_ready) rdyfall_q.push_back(cyc);
        if (!p_rdy && m_ready) rdyrise_q.push_back(cyc);
        p_sclk = m_sclk;
        p_ss   = m_ss;
        p_rdy  = m_ready;
    end

    task automatic test_reset();
        usrReset = 1'b1;
        txValid  = 1'b0;
        tx       = 8'h00;
        sel      = 1'b0;
        repeat (3) @(posedge clk);
        #1 usrReset = 1'b0;
        @(negedge clk);
        checks++; if (sclk8 !== 1'b1) begin errors++; $display("FAIL rst_sclk: got %b expected 1", sclk8); end
        checks++; if (ss8 !== 1'b1) begin errors++; $display("FAIL rst_ss: got %b expected 1", ss8); end
        checks++; if (mosi8 !== 1'b1) begin errors++; $display("FAIL rst_mosi: got %b expected 1", mosi8); end
        checks++; if (ready8 !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", ready8); end
        checks++; if (rxv8 !== 1'b0) begin errors++; $display("FAIL rst_rxvalid: got %b expected 0", rxv8); end
        checks++; if (rx8 !== 8'h00) begin errors++; $display("FAIL rst_rx: got %h expected 00", rx8); end
        checks++; if ({sclk4, ss4, mosi4, ready4, rxv4} !== 5'b11110) begin
            errors++; $display("FAIL rst_div4_pins: got %b expected 11110", {sclk4, ss4, mosi4, ready4, rxv4});
        end
    endtask

    task automatic test_loopback();
        int bf, br, bsf, bsr, brf, brr, bv, bov, t0, v;
        logic [7:0] mb;
        sel = 1'b0; miso_mode = 0; echo_en = 1'b0; s_ret = 8'h55;
        @(posedge clk); #1;
        bf = fall_q.size(); br = rise_q.size(); bsf = ssfall_q.size(); bsr = ssrise_q.size();
        brf = rdyfall_q.size(); brr = rdyrise_q.size(); bv = rxv_cyc_q.size(); bov = overlap_cnt;
        tx = 8'hAA; txValid = 1'b1; t0 = cyc;
        @(posedge clk); #1;
        txValid = 1'b0; tx = 8'h00;
        repeat (160) @(posedge clk);
        #1;
        v = (ssfall_q.size() > bsf) ? ssfall_q[bsf] - t0 : -1;
        checks++; if (v !== 1) begin errors++; $display("FAIL loop_ss_fall: got t0+%0d expected t0+1", v); end
        v = (rdyfall_q.size() > brf) ? rdyfall_q[brf] - t0 : -1;
        checks++; if (v !== 1) begin errors++; $display("FAIL loop_ready_fall: got t0+%0d expected t0+1", v); end
        checks++; if (fall_q.size() - bf !== 8) begin errors++; $display("FAIL loop_fall_count: got %0d expected 8", fall_q.size() - bf); end
        checks++; if (rise_q.size() - br !== 8) begin errors++; $display("FAIL loop_rise_count: got %0d expected 8", rise_q.size() - br); end
        for (int k = 0; k < 8; k++) begin
            v = (fall_q.size() > bf + k) ? fall_q[bf + k] - t0 : -1;
            checks++; if (v !== 1 + 8 * (1 + 2 * k)) begin
                errors++; $display("FAIL loop_fall_time[%0d]: got t0+%0d expected t0+%0d", k, v, 1 + 8 * (1 + 2 * k));
            end
            v = (rise_q.size() > br + k) ? rise_q[br + k] - t0 : -1;
            checks++; if (v !== 1 + 8 * (2 + 2 * k)) begin
                errors++; $display("FAIL loop_rise_time[%0d]: got t0+%0d expected t0+%0d", k, v, 1 + 8 * (2 + 2 * k));
            end
        end
        mb = 8'h00;
        for (int k = 0; k < 8; k++) mb = {mb[6:0], (mosi_rise_q.size() > br + k) ? mosi_rise_q[br + k] : 1'bx};
        checks++; if (mb !== 8'hAA) begin errors++; $display("FAIL loop_mosi_bits: got %h expected aa", mb); end
        checks++; if (rxv_cyc_q.size() - bv !== 1) begin errors++; $display("FAIL loop_rxv_count: got %0d expected 1", rxv_cyc_q.size() - bv); end
        v = (rxv_cyc_q.size() > bv) ? rxv_cyc_q[bv] - t0 : -1;
        checks++; if (v !== 137) begin errors++; $display("FAIL loop_rxv_time: got t0+%0d expected t0+137", v); end
        mb = (rxv_dat_q.size() > bv) ? rxv_dat_q[bv] : 8'hxx;
        checks++; if (mb !== 8'h55) begin errors++; $display("FAIL loop_rx_data: got %h expected 55", mb); end
        v = (ssrise_q.size() > bsr) ? ssrise_q[bsr] - t0 : -1;
        checks++; if (v !== 137) begin errors++; $display("FAIL loop_ss_rise: got t0+%0d expected t0+137", v); end
        v = (rdyrise_q.size() > brr) ? rdyrise_q[brr] - t0 : -1;
        checks++; if (v !== 145) begin errors++; $display("FAIL loop_ready_rise: got t0+%0d expected t0+145", v); end
        checks++; if (overlap_cnt - bov !== 0) begin errors++; $display("FAIL loop_rxv_ready_overlap: got %0d expected 0", overlap_cnt - bov); end
        checks++; if (s_echo !== 8'hAA) begin errors++; $display("FAIL loop_slave_rx: got %h expected aa", s_echo); end
        checks++; if (rx8 !== 8'h55) begin errors++; $display("FAIL loop_rx_hold: got %h expected 55", rx8); end
    endtask

    // Slave echoes the byte of the previous transaction (0xAA from loopback).
    task automatic test_back_to_back();
        int br, bsf, bsr, brf, brr, bv, t0, v;
        logic [7:0] mb;
        sel = 1'b0; miso_mode = 0; echo_en = 1'b1;
        @(posedge clk); #1;
        br = rise_q.size(); bsf = ssfall_q.size(); bsr = ssrise_q.size();
        brf = rdyfall_q.size(); brr = rdyrise_q.size(); bv = rxv_cyc_q.size();
        tx = 8'h01; txValid = 1'b1; t0 = cyc;
        @(posedge clk); #1;
        tx = 8'h80;
        repeat (145) @(posedge clk);
        #1 txValid = 1'b0;
        repeat (160) @(posedge clk);
        #1;
        v = (rdyrise_q.size() > brr) ? rdyrise_q[brr] - t0 : -1;
        checks++; if (v !== 145) begin errors++; $display("FAIL b2b_ready_rise: got t0+%0d expected t0+145", v); end
        v = (rdyfall_q.size() > brf + 1) ? rdyfall_q[brf + 1] - t0 : -1;
        checks++; if (v !== 146) begin errors++; $display("FAIL b2b_second_accept: got t0+%0d expected t0+146", v); end
        v = (ssfall_q.size() > bsf + 1 && ssrise_q.size() > bsr) ? ssfall_q[bsf + 1] - ssrise_q[bsr] : -1;
        checks++; if (v !== 9) begin errors++; $display("FAIL b2b_ss_gap: got %0d expected 9", v); end
        checks++; if (rxv_cyc_q.size() - bv !== 2) begin errors++; $display("FAIL b2b_rxv_count: got %0d expected 2", rxv_cyc_q.size() - bv); end
        mb = (rxv_dat_q.size() > bv) ? rxv_dat_q[bv] : 8'hxx;
        checks++; if (mb !== 8'hAA) begin errors++; $display("FAIL b2b_rx_first: got %h expected aa", mb); end
        mb = (rxv_dat_q.size() > bv + 1) ? rxv_dat_q[bv + 1] : 8'hxx;
        checks++; if (mb !== 8'h01) begin errors++; $display("FAIL b2b_rx_second: got %h expected 01", mb); end
        v = (rxv_cyc_q.size() > bv + 1) ? rxv_cyc_q[bv + 1] - t0 : -1;
        checks++; if (v !== 282) begin errors++; $display("FAIL b2b_rxv2_time: got t0+%0d expected t0+282", v); end
        mb = 8'h00;
        for (int k = 8; k < 16; k++) mb = {mb[6:0], (mosi_rise_q.size() > br + k) ? mosi_rise_q[br + k] : 1'bx};
        checks++; if (mb !== 8'h80) begin errors++; $display("FAIL b2b_mosi_second: got %h expected 80", mb); end
        echo_en = 1'b0;
    endtask

    task automatic test_edge_duty();
        int bf, br, bsf, bsr, t0, n, v, bad_in, bad_after;
        sel = 1'b1; miso_mode = 0; s_ret = 8'hC3;
        @(posedge clk); #1;
        bf = fall_q.size(); br = rise_q.size(); bsf = ssfall_q.size(); bsr = ssrise_q.size();
        tx = 8'h00; txValid = 1'b1; t0 = cyc;
        @(posedge clk); #1;
        txValid = 1'b0; tx = 8'hFF;
        bad_in = 0; bad_after = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            n = cyc - t0;
            if (n >= 5 && n <= 68 && m_mosi !== 1'b0) bad_in++;
            if (n >= 69 && m_mosi !== 1'b1) bad_after++;
        end
        repeat (10) @(posedge clk);
        #1;
        checks++; if (fall_q.size() - bf !== 8) begin errors++; $display("FAIL div4_fall_count: got %0d expected 8", fall_q.size() - bf); end
        checks++; if (rise_q.size() - br !== 8) begin errors++; $display("FAIL div4_rise_count: got %0d expected 8", rise_q.size() - br); end
        for (int k = 0; k < 8; k++) begin
            v = (rise_q.size() > br + k && fall_q.size() > bf + k) ? rise_q[br + k] - fall_q[bf + k] : -1;
            checks++; if (v !== 4) begin errors++; $display("FAIL div4_low_width[%0d]: got %0d expected 4", k, v); end
        end
        v = (ssrise_q.size() > bsr && ssfall_q.size() > bsf) ? ssrise_q[bsr] - ssfall_q[bsf] : -1;
        checks++; if (v !== 68) begin errors++; $display("FAIL div4_ss_low: got %0d expected 68", v); end
        checks++; if (bad_in !== 0) begin errors++; $display("FAIL div4_mosi_low: got %0d bad cycles expected 0", bad_in); end
        checks++; if (bad_after !== 0) begin errors++; $display("FAIL div4_mosi_idle: got %0d bad cycles expected 0", bad_after); end
        checks++; if (rx4 !== 8'hC3) begin errors++; $display("FAIL div4_rx: got %h expected c3", rx4); end
        sel = 1'b0;
    endtask

    task automatic test_busy_drop();
        int br, bsf, brf, bv;
        logic [7:0] mb;
        sel = 1'b0; miso_mode = 0; s_ret = 8'h5A;
        @(posedge clk); #1;
        br = rise_q.size(); bsf = ssfall_q.size(); brf = rdyfall_q.size(); bv = rxv_cyc_q.size();
        tx = 8'h3C; txValid = 1'b1;
        @(posedge clk); #1;
        txValid = 1'b0;
        repeat (49) @(posedge clk);
        #1 tx = 8'hFF; txValid = 1'b1;
        @(posedge clk); #1;
        txValid = 1'b0;
        repeat (250) @(posedge clk);
        #1;
        mb = 8'h00;
        for (int k = 0; k < 8; k++) mb = {mb[6:0], (mosi_rise_q.size() > br + k) ? mosi_rise_q[br + k] : 1'bx};
        checks++; if (mb !== 8'h3C) begin errors++; $display("FAIL busy_mosi: got %h expected 3c", mb); end
        checks++; if (rise_q.size() - br !== 8) begin errors++; $display("FAIL busy_rise_count: got %0d expected 8", rise_q.size() - br); end
        checks++; if (ssfall_q.size() - bsf !== 1) begin errors++; $display("FAIL busy_ss_count: got %0d expected 1", ssfall_q.size() - bsf); end
        checks++; if (rdyfall_q.size() - brf !== 1) begin errors++; $display("FAIL busy_accept_count: got %0d expected 1", rdyfall_q.size() - brf); end
        checks++; if (rxv_cyc_q.size() - bv !== 1) begin errors++; $display("FAIL busy_rxv_count: got %0d expected 1", rxv_cyc_q.size() - bv); end
        checks++; if (rx8 !== 8'h5A) begin errors++; $display("FAIL busy_rx: got %h expected 5a", rx8); end
        checks++; if (s_echo !== 8'h3C) begin errors++; $display("FAIL busy_slave_rx: got %h expected 3c", s_echo); end
    endtask

    task automatic test_miso_const(input int mode, input logic [7:0] exp_rx);
        int bv;
        sel = 1'b0; miso_mode = mode;
        @(posedge clk); #1;
        bv = rxv_cyc_q.size();
        tx = 8'h96; txValid = 1'b1;
        @(posedge clk); #1;
        txValid = 1'b0;
        repeat (160) @(posedge clk);
        #1;
        checks++; if (rxv_cyc_q.size() - bv !== 1) begin errors++; $display("FAIL miso_const%0d_rxv: got %0d expected 1", mode, rxv_cyc_q.size() - bv); end
        checks++; if (rx8 !== exp_rx) begin errors++; $display("FAIL miso_const%0d_rx: got %h expected %h", mode, rx8, exp_rx); end
        miso_mode = 0;
    endtask

    // Entered with rx = 8'hFF from the constant-1 run.
    task automatic test_reset_mid();
        int br, bv;
        sel = 1'b0; miso_mode = 0; s_ret = 8'h81;
        @(posedge clk); #1;
        br = rise_q.size(); bv = rxv_cyc_q.size();
        tx = 8'h3C; txValid = 1'b1;
        @(posedge clk); #1;
        txValid = 1'b0;
        repeat (65) @(posedge clk);
        #1;
        checks++; if (rise_q.size() - br !== 4) begin errors++; $display("FAIL rstmid_rises_before: got %0d expected 4", rise_q.size() - br); end
        checks++; if (rx8 !== 8'hFF) begin errors++; $display("FAIL rstmid_rx_before: got %h expected ff", rx8); end
        usrReset = 1'b1;
        @(posedge clk); #1;
        usrReset = 1'b0;
        @(negedge clk);
        checks++; if (ss8 !== 1'b1) begin errors++; $display("FAIL rstmid_ss: got %b expected 1", ss8); end
        checks++; if (sclk8 !== 1'b1) begin errors++; $display("FAIL rstmid_sclk: got %b expected 1", sclk8); end
        checks++; if (mosi8 !== 1'b1) begin errors++; $display("FAIL rstmid_mosi: got %b expected 1", mosi8); end
        checks++; if (rx8 !== 8'h00) begin errors++; $display("FAIL rstmid_rx: got %h expected 00", rx8); end
        checks++; if (ready8 !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", ready8); end
        repeat (200) @(posedge clk);
        #1;
        checks++; if (rxv_cyc_q.size() - bv !== 0) begin errors++; $display("FAIL rstmid_no_rxv: got %0d expected 0", rxv_cyc_q.size() - bv); end
        checks++; if (rise_q.size() - br !== 4) begin errors++; $display("FAIL rstmid_rises_after: got %0d expected 4", rise_q.size() - br); end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_back_to_back();
        test_edge_duty();
        test_busy_drop();
        test_miso_const(1, 8'h00);
        test_miso_const(2, 8'hFF);
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
